rob_ptr_ctrl: RTL and testbench

- Pointer and occupancy controller for the 64-entry reorder buffer.
- Allocates up to 2 tail entries per cycle for dispatch and retires up to 2 completed head entries per cycle, strictly in order.
- Raises dispatch stall on insufficient space.
- On flush, sequences a rollback walk from tail back to head so rename can restore mappings.
- Owns head/tail/count; the ROB storage array only reads indices from this block.

---
 rtl/rob_ptr_ctrl.sv | 130 +++++++++++++
 tb/tb_rob_ptr_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rob_ptr_ctrl.sv
// Head/tail/occupancy controller for the reorder buffer: 2-wide dispatch, 2-wide in-order retire, flush rollback walk.
// Optional saturating performance counters are enabled by defining ROB_PERF_CNT_EN.
module rob_ptr_ctrl #(
  parameter int DEPTH = 64,
  parameter int PTR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       disp_req,
  output logic [1:0]       disp_grant,
  output logic [PTR_W-1:0] alloc_idx_0,
  output logic [PTR_W-1:0] alloc_idx_1,
  input  logic             head_cmpl_0,
  input  logic             head_cmpl_1,
  output logic [1:0]       retire_cnt,
  output logic [PTR_W-1:0] retire_idx_0,
  output logic [PTR_W-1:0] retire_idx_1,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic [1:0]       rb_valid,
  output logic [PTR_W-1:0] rb_idx_0,
  output logic [PTR_W-1:0] rb_idx_1,
  output logic             stall,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cyc,
  output logic [31:0]      perf_retired,
  output logic [15:0]      perf_flushes
`endif
);

  localparam int CW = PTR_W + 1;
  localparam logic [PTR_W:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, WALK} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] head, tail;
  logic [1:0]       req_eff;
  logic [1:0]       rb_pop;
  logic [PTR_W:0]   free;

  assign req_eff      = (disp_req == 2'd3) ? 2'd2 : disp_req;
  // Free space uses the registered count only; same-cycle retires are credited next cycle.
  assign free         = DEPTH_C - count;
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign alloc_idx_0  = tail;
  assign alloc_idx_1  = tail + PTR_W'(1);
  assign retire_idx_0 = head;
  assign retire_idx_1 = head + PTR_W'(1);
  assign rb_idx_0     = tail - PTR_W'(1);
  assign rb_idx_1     = tail - PTR_W'(2);

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    disp_grant = 2'd0;
    retire_cnt = 2'd0;
    stall      = 1'b0;
    flush_busy = 1'b0;
    rb_valid   = 2'b00;
    rb_pop     = 2'd0;
    case (state)
      RUN: begin
        if (flush_req) begin
          stall = 1'b1;
          if (count != '0) state_nxt = WALK;
        end else begin
          if (CW'(req_eff) <= free) disp_grant = req_eff;
          else                      stall      = 1'b1;
          if (!empty && head_cmpl_0) begin
            retire_cnt = (count >= CW'(2) && head_cmpl_1) ? 2'd2 : 2'd1;
          end
        end
      end
      WALK: begin
        flush_busy = 1'b1;
        stall      = 1'b1;
        rb_valid   = (count >= CW'(2)) ? 2'b11 : 2'b01;
        rb_pop     = (count >= CW'(2)) ? 2'd2 : 2'd1;
        if (count == CW'(rb_pop)) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (state == WALK) begin
        tail  <= tail - PTR_W'(rb_pop);
        count <= count - CW'(rb_pop);
      end else begin
        head  <= head + PTR_W'(retire_cnt);
        tail  <= tail + PTR_W'(disp_grant);
        count <= count + CW'(disp_grant) - CW'(retire_cnt);
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  logic [32:0] retired_sum;
  assign retired_sum = {1'b0, perf_retired} + 33'(retire_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cyc <= '0;
      perf_retired   <= '0;
      perf_flushes   <= '0;
    end else begin
      if (stall && disp_req != 2'd0 && state != WALK && perf_stall_cyc != '1)
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      perf_retired <= retired_sum[32] ? '1 : retired_sum[31:0];
      if (state == RUN && flush_req && count != '0 && perf_flushes != '1)
        perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// Directed self-checking bench for rob_ptr_ctrl: dispatch, full stall, wrap retire, in-order retire, flush walk, reset mid-walk.
module tb_rob_ptr_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] disp_req;
  logic [1:0] disp_grant;
  logic [5:0] alloc_idx_0, alloc_idx_1;
  logic       head_cmpl_0, head_cmpl_1;
  logic [1:0] retire_cnt;
  logic [5:0] retire_idx_0, retire_idx_1;
  logic       flush_req, flush_busy;
  logic [1:0] rb_valid;
  logic [5:0] rb_idx_0, rb_idx_1;
  logic       stall;
  logic [6:0] count;
  logic       full, empty;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_retired;
  logic [15:0] perf_flushes;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rob_ptr_ctrl #(.DEPTH(64), .PTR_W(6)) dut (
    .clk(clk), .rst(rst), .disp_req(disp_req), .disp_grant(disp_grant),
    .alloc_idx_0(alloc_idx_0), .alloc_idx_1(alloc_idx_1),
    .head_cmpl_0(head_cmpl_0), .head_cmpl_1(head_cmpl_1),
    .retire_cnt(retire_cnt), .retire_idx_0(retire_idx_0), .retire_idx_1(retire_idx_1),
    .flush_req(flush_req), .flush_busy(flush_busy), .rb_valid(rb_valid),
    .rb_idx_0(rb_idx_0), .rb_idx_1(rb_idx_1), .stall(stall),
    .count(count), .full(full), .empty(empty)
`ifdef ROB_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_retired(perf_retired), .perf_flushes(perf_flushes)
`endif
  );

  // Advance one edge and settle just after it; inputs change here, away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; disp_req = 2'd0; head_cmpl_0 = 1'b0; head_cmpl_1 = 1'b0; flush_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; disp_req = 2'd0; head_cmpl_0 = 1'b0; head_cmpl_1 = 1'b0; flush_req = 1'b0;
    #2;
    n_cmp++; if (count !== 7'd0)        begin n_err++; $display("FAIL rst_count got %0d exp 0", count); end
    n_cmp++; if (empty !== 1'b1)        begin n_err++; $display("FAIL rst_empty got %0b exp 1", empty); end
    n_cmp++; if (full !== 1'b0)         begin n_err++; $display("FAIL rst_full got %0b exp 0", full); end
    n_cmp++; if (flush_busy !== 1'b0)   begin n_err++; $display("FAIL rst_busy got %0b exp 0", flush_busy); end
    n_cmp++; if (rb_valid !== 2'b00)    begin n_err++; $display("FAIL rst_rbv got %0b exp 00", rb_valid); end
    n_cmp++; if (stall !== 1'b0)        begin n_err++; $display("FAIL rst_stall got %0b exp 0", stall); end
    n_cmp++; if (disp_grant !== 2'd0)   begin n_err++; $display("FAIL rst_grant got %0d exp 0", disp_grant); end
    n_cmp++; if (alloc_idx_0 !== 6'd0)  begin n_err++; $display("FAIL rst_tail got %0d exp 0", alloc_idx_0); end
    n_cmp++; if (retire_idx_0 !== 6'd0) begin n_err++; $display("FAIL rst_head got %0d exp 0", retire_idx_0); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_dispatch();
    logic [5:0] exp_idx [3] = '{6'd0, 6'd2, 6'd4};
    for (int i = 0; i < 3; i++) begin
      disp_req = 2'd2;
      #1;
      n_cmp++; if (alloc_idx_0 !== exp_idx[i]) begin n_err++; $display("FAIL disp_idx%0d got %0d exp %0d", i, alloc_idx_0, exp_idx[i]); end
      n_cmp++; if (disp_grant !== 2'd2) begin n_err++; $display("FAIL disp_grant%0d got %0d exp 2", i, disp_grant); end
      step();
    end
    disp_req = 2'd0;
    n_cmp++; if (count !== 7'd6)       begin n_err++; $display("FAIL disp_count got %0d exp 6", count); end
    n_cmp++; if (alloc_idx_0 !== 6'd6) begin n_err++; $display("FAIL disp_tail got %0d exp 6", alloc_idx_0); end
    n_cmp++; if (empty !== 1'b0)       begin n_err++; $display("FAIL disp_empty got %0b exp 0", empty); end
  endtask

  task automatic test_full_stall();
    for (int i = 0; i < 28; i++) begin disp_req = 2'd3; step(); end
    n_cmp++; if (count !== 7'd62) begin n_err++; $display("FAIL fill_req3_count got %0d exp 62", count); end
    disp_req = 2'd1; step();
    n_cmp++; if (count !== 7'd63) begin n_err++; $display("FAIL fill_count got %0d exp 63", count); end
    disp_req = 2'd2; #1;
    n_cmp++; if (disp_grant !== 2'd0) begin n_err++; $display("FAIL f63_grant got %0d exp 0", disp_grant); end
    n_cmp++; if (stall !== 1'b1)      begin n_err++; $display("FAIL f63_stall got %0b exp 1", stall); end
    step();
    disp_req = 2'd1; #1;
    n_cmp++; if (disp_grant !== 2'd1) begin n_err++; $display("FAIL f63_grant1 got %0d exp 1", disp_grant); end
    step();
    n_cmp++; if (full !== 1'b1)        begin n_err++; $display("FAIL full got %0b exp 1", full); end
    n_cmp++; if (count !== 7'd64)      begin n_err++; $display("FAIL full_count got %0d exp 64", count); end
    n_cmp++; if (alloc_idx_0 !== 6'd0) begin n_err++; $display("FAIL full_tail_wrap got %0d exp 0", alloc_idx_0); end
    disp_req = 2'd1; head_cmpl_0 = 1'b1; #1;
    n_cmp++; if (disp_grant !== 2'd0) begin n_err++; $display("FAIL full_ret_grant got %0d exp 0", disp_grant); end
    n_cmp++; if (retire_cnt !== 2'd1) begin n_err++; $display("FAIL full_ret_cnt got %0d exp 1", retire_cnt); end
    step();
    head_cmpl_0 = 1'b0; #1;
    n_cmp++; if (disp_grant !== 2'd1) begin n_err++; $display("FAIL after_ret_grant got %0d exp 1", disp_grant); end
    step();
    n_cmp++; if (count !== 7'd64) begin n_err++; $display("FAIL refill_count got %0d exp 64", count); end
    disp_req = 2'd2; head_cmpl_0 = 1'b1; head_cmpl_1 = 1'b1; #1;
    n_cmp++; if (disp_grant !== 2'd0 || retire_cnt !== 2'd2) begin n_err++; $display("FAIL full_ret2 grant/ret got %0d/%0d exp 0/2", disp_grant, retire_cnt); end
    step();
    head_cmpl_0 = 1'b0; head_cmpl_1 = 1'b0; #1;
    n_cmp++; if (disp_grant !== 2'd2) begin n_err++; $display("FAIL after_ret2_grant got %0d exp 2", disp_grant); end
    step();
    disp_req = 2'd0;
    n_cmp++; if (count !== 7'd64) begin n_err++; $display("FAIL after_ret2_count got %0d exp 64", count); end
  endtask

  task automatic test_retire_wrap();
    do_reset();
    for (int i = 0; i < 31; i++) begin disp_req = 2'd2; step(); end
    disp_req = 2'd0; head_cmpl_0 = 1'b1; head_cmpl_1 = 1'b1;
    for (int i = 0; i < 31; i++) step();
    head_cmpl_0 = 1'b0; head_cmpl_1 = 1'b0;
    disp_req = 2'd2; step(); step();
    disp_req = 2'd1; step();
    disp_req = 2'd0;
    n_cmp++; if (count !== 7'd5 || retire_idx_0 !== 6'd62) begin n_err++; $display("FAIL wrap_setup count/head got %0d/%0d exp 5/62", count, retire_idx_0); end
    head_cmpl_0 = 1'b1; head_cmpl_1 = 1'b1; #1;
    n_cmp++; if (retire_cnt !== 2'd2 || retire_idx_0 !== 6'd62 || retire_idx_1 !== 6'd63) begin n_err++; $display("FAIL wrap_ret1 cnt/i0/i1 got %0d/%0d/%0d exp 2/62/63", retire_cnt, retire_idx_0, retire_idx_1); end
    step();
    n_cmp++; if (retire_cnt !== 2'd2 || retire_idx_0 !== 6'd0 || retire_idx_1 !== 6'd1) begin n_err++; $display("FAIL wrap_ret2 cnt/i0/i1 got %0d/%0d/%0d exp 2/0/1", retire_cnt, retire_idx_0, retire_idx_1); end
    step();
    n_cmp++; if (retire_idx_0 !== 6'd2 || count !== 7'd1) begin n_err++; $display("FAIL wrap_after head/count got %0d/%0d exp 2/1", retire_idx_0, count); end
  endtask

  task automatic test_in_order();
    head_cmpl_0 = 1'b0; head_cmpl_1 = 1'b1; #1;
    n_cmp++; if (retire_cnt !== 2'd0) begin n_err++; $display("FAIL in_order got %0d exp 0", retire_cnt); end
    head_cmpl_0 = 1'b1; #1;
    n_cmp++; if (retire_cnt !== 2'd1) begin n_err++; $display("FAIL cnt1_limit got %0d exp 1", retire_cnt); end
    step();
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL drain_empty got %0b exp 1", empty); end
    n_cmp++; if (retire_cnt !== 2'd0) begin n_err++; $display("FAIL empty_retire got %0d exp 0", retire_cnt); end
    head_cmpl_0 = 1'b0; head_cmpl_1 = 1'b0;
  endtask

  task automatic test_flush_walk();
    do_reset();
    for (int i = 0; i < 5; i++) begin disp_req = 2'd2; step(); end
    disp_req = 2'd0; head_cmpl_0 = 1'b1; head_cmpl_1 = 1'b1; step(); step();
    head_cmpl_1 = 1'b0; step();
    n_cmp++; if (count !== 7'd5 || alloc_idx_0 !== 6'd10) begin n_err++; $display("FAIL fl_setup count/tail got %0d/%0d exp 5/10", count, alloc_idx_0); end
    head_cmpl_1 = 1'b1; flush_req = 1'b1; disp_req = 2'd2; #1;
    n_cmp++; if (disp_grant !== 2'd0 || stall !== 1'b1 || retire_cnt !== 2'd0) begin n_err++; $display("FAIL fl_req grant/stall/ret got %0d/%0b/%0d exp 0/1/0", disp_grant, stall, retire_cnt); end
    step();
    n_cmp++; if (flush_busy !== 1'b1 || rb_valid !== 2'b11 || rb_idx_0 !== 6'd9 || rb_idx_1 !== 6'd8) begin n_err++; $display("FAIL walk1 busy/v/i0/i1 got %0b/%0b/%0d/%0d exp 1/11/9/8", flush_busy, rb_valid, rb_idx_0, rb_idx_1); end
    n_cmp++; if (disp_grant !== 2'd0 || retire_cnt !== 2'd0 || stall !== 1'b1) begin n_err++; $display("FAIL walk1_block grant/ret/stall got %0d/%0d/%0b exp 0/0/1", disp_grant, retire_cnt, stall); end
    step();
    n_cmp++; if (flush_busy !== 1'b1 || rb_valid !== 2'b11 || rb_idx_0 !== 6'd7 || rb_idx_1 !== 6'd6) begin n_err++; $display("FAIL walk2 busy/v/i0/i1 got %0b/%0b/%0d/%0d exp 1/11/7/6", flush_busy, rb_valid, rb_idx_0, rb_idx_1); end
    step();
    n_cmp++; if (flush_busy !== 1'b1 || rb_valid !== 2'b01 || rb_idx_0 !== 6'd5) begin n_err++; $display("FAIL walk3 busy/v/i0 got %0b/%0b/%0d exp 1/01/5", flush_busy, rb_valid, rb_idx_0); end
    step();
    flush_req = 1'b0; disp_req = 2'd0; head_cmpl_0 = 1'b0; head_cmpl_1 = 1'b0; #1;
    n_cmp++; if (flush_busy !== 1'b0 || count !== 7'd0 || alloc_idx_0 !== 6'd5 || retire_idx_0 !== 6'd5) begin n_err++; $display("FAIL walk_done busy/count/tail/head got %0b/%0d/%0d/%0d exp 0/0/5/5", flush_busy, count, alloc_idx_0, retire_idx_0); end
    flush_req = 1'b1; step();
    flush_req = 1'b0;
    n_cmp++; if (flush_busy !== 1'b0) begin n_err++; $display("FAIL flush_empty_busy got %0b exp 0", flush_busy); end
  endtask

  task automatic test_reset_mid_walk();
    for (int i = 0; i < 3; i++) begin disp_req = 2'd2; step(); end
    disp_req = 2'd0; flush_req = 1'b1; step();
    flush_req = 1'b0; step();
    n_cmp++; if (flush_busy !== 1'b1 || rb_idx_0 !== 6'd8) begin n_err++; $display("FAIL mid_walk busy/i0 got %0b/%0d exp 1/8", flush_busy, rb_idx_0); end
    rst = 1'b1; #1;
    n_cmp++; if (count !== 7'd0 || flush_busy !== 1'b0 || empty !== 1'b1 || rb_valid !== 2'b00) begin n_err++; $display("FAIL rst_walk count/busy/empty/v got %0d/%0b/%0b/%0b exp 0/0/1/00", count, flush_busy, empty, rb_valid); end
    n_cmp++; if (alloc_idx_0 !== 6'd0 || retire_idx_0 !== 6'd0) begin n_err++; $display("FAIL rst_walk tail/head got %0d/%0d exp 0/0", alloc_idx_0, retire_idx_0); end
    step();
    rst = 1'b0; disp_req = 2'd1; #1;
    n_cmp++; if (disp_grant !== 2'd1 || stall !== 1'b0) begin n_err++; $display("FAIL post_rst grant/stall got %0d/%0b exp 1/0", disp_grant, stall); end
    step();
    disp_req = 2'd0;
  endtask

  initial begin
    test_reset();
    test_dispatch();
    test_full_stall();
    test_retire_wrap();
    test_in_order();
    test_flush_walk();
    test_reset_mid_walk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
